// File: rtl/spongent_pkg.sv
// Shared Spongent constants, control-state encoding and the bit-permutation index maps.
// Used by both the forward layer and the serial inverse player.
package spongent_pkg;

  localparam int unsigned STATE_W = 264;
  localparam int unsigned NSBOX   = STATE_W / 8;
  localparam int unsigned SLICE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // P(j): destination of bit j in the forward layer; the top bit is a fixed point.
  function automatic int unsigned perm_idx(input int unsigned j,
                                           input int unsigned w = STATE_W);
    if (j >= w - 1) return w - 1;
    return (j * w / 4) % (w - 1);
  endfunction

  // Pinv(i): inverse of P.
  function automatic int unsigned inv_perm_idx(input int unsigned i,
                                               input int unsigned w = STATE_W);
    if (i >= w - 1) return w - 1;
    return (4 * i) % (w - 1);
  endfunction

endpackage

// File: rtl/inv_player_serial_if.sv
// Start/done handshake and state buses of the serial permutation player.
// The dir signal exists only when SPONGENT_FWD_EN is defined.
interface inv_player_serial_if #(
  parameter int unsigned STATE_W = spongent_pkg::STATE_W
) ();

  logic               start;
  logic [STATE_W-1:0] state_in;
`ifdef SPONGENT_FWD_EN
  logic               dir;
`endif
  logic               busy;
  logic               done;
  logic               out_valid;
  logic [STATE_W-1:0] state_out;

  modport master (
    output start,
    output state_in,
`ifdef SPONGENT_FWD_EN
    output dir,
`endif
    input  busy,
    input  done,
    input  out_valid,
    input  state_out
  );

  modport slave (
    input  start,
    input  state_in,
`ifdef SPONGENT_FWD_EN
    input  dir,
`endif
    output busy,
    output done,
    output out_valid,
    output state_out
  );

endinterface

// File: rtl/inv_player_serial_perm_slice_gather.sv
// Combinational gather of one SLICE_W-bit output slice of the permuted state.
// With SPONGENT_FWD_EN, dir_i=1 selects the forward map instead of the inverse one.
module perm_slice_gather #(
  parameter int unsigned STATE_W = spongent_pkg::STATE_W,
  parameter int unsigned SLICE_W = spongent_pkg::SLICE_W,
  parameter int unsigned CNT_W   = 6
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [CNT_W-1:0]   k_i,
`ifdef SPONGENT_FWD_EN
  input  logic               dir_i,
`endif
  output logic [SLICE_W-1:0] slice_c
);
  import spongent_pkg::*;

  localparam int unsigned NS = STATE_W / SLICE_W;

  logic [STATE_W-1:0] inv_full;
  logic [STATE_W-1:0] sel_full;

  // Both maps are fixed wiring; only the slice selection is real logic.
  for (genvar j = 0; j < STATE_W; j++) begin : g_inv
    assign inv_full[j] = state_i[perm_idx(j, STATE_W)];
  end

`ifdef SPONGENT_FWD_EN
  logic [STATE_W-1:0] fwd_full;

  for (genvar j = 0; j < STATE_W; j++) begin : g_fwd
    assign fwd_full[j] = state_i[inv_perm_idx(j, STATE_W)];
  end

  assign sel_full = dir_i ? fwd_full : inv_full;
`else
  assign sel_full = inv_full;
`endif

  always_comb begin
    slice_c = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (k_i == CNT_W'(s)) slice_c = sel_full[s*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/inv_player_serial.sv
// Byte-serial inverse Spongent bit-permutation layer behind a start/done handshake.
// Optional forward mode (dir port) is built when SPONGENT_FWD_EN is defined.
module inv_player_serial #(
  parameter int unsigned STATE_W = spongent_pkg::STATE_W,
  parameter int unsigned SLICE_W = spongent_pkg::SLICE_W
) (
  input logic               clk,
  input logic               rst,
  inv_player_serial_if.slave bus
);
  import spongent_pkg::*;

  localparam int unsigned NS     = STATE_W / SLICE_W;
  localparam int unsigned CNT_W  = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NS - 1);

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [STATE_W-1:0] cap_q, cap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] state_out_q, state_out_d;
  logic [SLICE_W-1:0] slice_c;
`ifdef SPONGENT_FWD_EN
  logic               dir_q, dir_d;
`endif

  perm_slice_gather #(
    .STATE_W (STATE_W),
    .SLICE_W (SLICE_W),
    .CNT_W   (CNT_W)
  ) u_gather (
    .state_i (cap_q),
    .k_i     (k_q),
`ifdef SPONGENT_FWD_EN
    .dir_i   (dir_q),
`endif
    .slice_c (slice_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cap_d       = cap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    state_out_d = state_out_q;
`ifdef SPONGENT_FWD_EN
    dir_d       = dir_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cap_d       = bus.state_in;
`ifdef SPONGENT_FWD_EN
          dir_d       = bus.dir;
`endif
          k_d         = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned s = 0; s < NS; s++) begin
          if (k_q == CNT_W'(s)) state_out_d[s*SLICE_W +: SLICE_W] = slice_c;
        end
        k_d = k_q + CNT_W'(1);
        if (k_q == LAST_K) begin
          k_d         = '0;
          done_d      = 1'b1;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      cap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      state_out_q <= '0;
`ifdef SPONGENT_FWD_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
`ifdef SPONGENT_FWD_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_inv_player_serial.sv
// Randomized self-checking bench for inv_player_serial against a scatter-based bit model.
// Forward-mode checks are compiled in when SPONGENT_FWD_EN is defined.
module tb_inv_player_serial;

  localparam int unsigned SW  = 264;
  localparam int unsigned NSL = 33;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  inv_player_serial_if #(.STATE_W(SW)) bus ();

  inv_player_serial #(.STATE_W(SW), .SLICE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward layer as a scatter: bit j of x lands at position j*b/4 mod (b-1).
  function automatic logic [SW-1:0] model_fwd(input logic [SW-1:0] x);
    logic [SW-1:0] y;
    y = '0;
    for (int j = 0; j < SW - 1; j++) y[(j * (SW / 4)) % (SW - 1)] = x[j];
    y[SW-1] = x[SW-1];
    return y;
  endfunction

  // Inverse layer as a scatter: bit i of y goes back to position 4*i mod (b-1).
  function automatic logic [SW-1:0] model_inv(input logic [SW-1:0] y);
    logic [SW-1:0] x;
    x = '0;
    for (int i = 0; i < SW - 1; i++) x[(4 * i) % (SW - 1)] = y[i];
    x[SW-1] = y[SW-1];
    return x;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] r;
    r = '0;
    for (int w = 0; w < 9; w++) r = {r[SW-33:0], 32'($urandom)};
    return r;
  endfunction

  // One operation from an idle sample point; optionally pulses start mid-run.
  task automatic run_op(input logic [SW-1:0] y, input logic [SW-1:0] exp,
                        input string tag, input int pulse_at);
    int cnt;
    bus.start    = 1'b1;
    bus.state_in = y;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.state_in = rand_state();
    check({tag, "_ov_clr"}, SW'(bus.out_valid), SW'(0));
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      if (cnt == pulse_at) begin
        bus.start    = 1'b1;
        bus.state_in = rand_state();
      end else begin
        bus.start = 1'b0;
      end
      cnt++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check({tag, "_busy_cycles"}, SW'(cnt), SW'(NSL));
    check({tag, "_done"}, SW'(bus.done), SW'(1));
    check({tag, "_ov"}, SW'(bus.out_valid), SW'(1));
    check({tag, "_out"}, bus.state_out, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, SW'(bus.done), SW'(0));
    check({tag, "_hold"}, bus.state_out, exp);
  endtask

  initial begin
    logic [SW-1:0] x;
    logic [SW-1:0] y;
    logic [SW-1:0] e;
    int            last_done;
    int            n_done;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.start    = 1'b0;
    bus.state_in = '0;
`ifdef SPONGENT_FWD_EN
    bus.dir      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", SW'(bus.busy), SW'(0));
    check("rst_done", SW'(bus.done), SW'(0));
    check("rst_ov", SW'(bus.out_valid), SW'(0));
    check("rst_out", bus.state_out, SW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed boundary bits.
    y = SW'(1) << 1;   e = SW'(1) << 4;   run_op(y, e, "bit1", -1);
    y = SW'(1) << 66;  e = SW'(1) << 1;   run_op(y, e, "bit66", -1);
    y = SW'(1) << 263; e = SW'(1) << 263; run_op(y, e, "bit263", -1);
    y = '1;            e = '1;            run_op(y, e, "ones", -1);
    y = '0;            e = '0;            run_op(y, e, "zero", -1);

    // Random inverse against the scatter model, then random round trips.
    for (int n = 0; n < 10; n++) begin
      y = rand_state();
      run_op(y, model_inv(y), "rand_inv", -1);
    end
    for (int n = 0; n < 50; n++) begin
      x = rand_state();
      run_op(model_fwd(x), x, "round_trip", -1);
    end

    // Start pulsed mid-run is ignored.
    x = rand_state();
    run_op(model_fwd(x), x, "mid_pulse", 5);

    // Start held high: a done every NS+1 cycles.
    x = rand_state();
    bus.start    = 1'b1;
    bus.state_in = model_fwd(x);
    last_done = -1;
    n_done    = 0;
    for (int c = 0; c < 300 && n_done < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (last_done >= 0) check("hold_gap", SW'(c - last_done), SW'(NSL + 1));
        check("hold_out", bus.state_out, x);
        last_done = c;
        n_done++;
      end
    end
    bus.start = 1'b0;
    check("hold_count", SW'(n_done), SW'(3));
    @(posedge clk); #1;

    // Reset in the middle of a run.
    bus.start    = 1'b1;
    bus.state_in = rand_state();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_pre_busy", SW'(bus.busy), SW'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", SW'(bus.busy), SW'(0));
    check("mid_rst_done", SW'(bus.done), SW'(0));
    check("mid_rst_ov", SW'(bus.out_valid), SW'(0));
    check("mid_rst_out", bus.state_out, SW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", SW'(bus.busy), SW'(0));
    check("post_rst_nodone", SW'(bus.done), SW'(0));
    x = rand_state();
    run_op(model_fwd(x), x, "post_rst", -1);

`ifdef SPONGENT_FWD_EN
    bus.dir = 1'b1;
    y = SW'(1) << 1; e = SW'(1) << 66; run_op(y, e, "fwd_bit1", -1);
    bus.dir = 1'b0;
    e = SW'(1) << 4; run_op(y, e, "inv_bit1", -1);
    for (int n = 0; n < 10; n++) begin
      bus.dir = 1'b1;
      x = rand_state();
      run_op(x, model_fwd(x), "rand_fwd", -1);
    end
    bus.dir = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
